// File: rtl/datapath_pkg.sv
// rtl/datapath_pkg.sv - shared opcode constants and bus-source ordering for the Mini-SRC datapath
package datapath_pkg;

    // ALU operation codes
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    // Bus sources, listed from highest to lowest priority
    typedef enum logic [2:0] {
        SRC_MDR,
        SRC_PC,
        SRC_ZHIGH,
        SRC_ZLOW,
        SRC_HI,
        SRC_LO,
        SRC_GPR,
        SRC_NONE
    } bus_src_e;

endpackage

// File: rtl/datapath_alu.sv
// rtl/datapath_alu.sv - combinational ALU, 64-bit result
// Ports:
//   a      in  WIDTH    first operand (Y register)
//   b      in  WIDTH    second operand (bus)
//   cin    in  1        carry-in for ADD/SUB
//   opcode in  5        operation select
//   c      out 2*WIDTH  result; upper half zero except for MUL and DIV
module datapath_alu
    import datapath_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               cin,
    input  logic [4:0]         opcode,
    output logic [2*WIDTH-1:0] c
);

    logic [4:0]         shamt;
    logic [2*WIDTH-1:0] rot_r;
    logic [2*WIDTH-1:0] rot_l;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   quotient;
    logic [WIDTH-1:0]   remainder;

    assign shamt = b[4:0];

    // Rotations via a doubled copy so a zero shift amount needs no special case
    assign rot_r = {a, a} >> shamt;
    assign rot_l = {a, a} << shamt;

    assign product = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});

    always_comb begin
        quotient  = '0;
        remainder = '0;
        if (b != '0) begin
            quotient  = $signed(a) / $signed(b);
            remainder = $signed(a) % $signed(b);
        end
    end

    always_comb begin
        c = '0;
        case (opcode)
            OP_ADD:  c[WIDTH-1:0] = a + b + {{(WIDTH-1){1'b0}}, cin};
            OP_SUB:  c[WIDTH-1:0] = a - b - {{(WIDTH-1){1'b0}}, cin};
            OP_AND:  c[WIDTH-1:0] = a & b;
            OP_OR:   c[WIDTH-1:0] = a | b;
            OP_SHR:  c[WIDTH-1:0] = a >> shamt;
            OP_SHRA: c[WIDTH-1:0] = $signed(a) >>> shamt;
            OP_SHL:  c[WIDTH-1:0] = a << shamt;
            OP_ROR:  c[WIDTH-1:0] = rot_r[WIDTH-1:0];
            OP_ROL:  c[WIDTH-1:0] = rot_l[2*WIDTH-1:WIDTH];
            OP_MUL:  c = product;
            OP_DIV:  c = {remainder, quotient};
            OP_NEG:  c[WIDTH-1:0] = -b;
            OP_NOT:  c[WIDTH-1:0] = ~b;
            default: c = '0;
        endcase
    end

endmodule

// File: rtl/datapath.sv
// rtl/datapath.sv - Mini-SRC single-bus datapath: registers, bus mux and ALU
// Ports:
//   clock, clear            clock and asynchronous active-low reset
//   Mdatain, Read           memory read data and MDR source select (1 = memory)
//   *out, R0_15_out         bus drive enables (priority resolved here)
//   *in, R0in/R6in/R7in     register load enables
//   IncPC                   with PCin, loads PC+1 instead of the bus
//   Cin, opcode             ALU carry-in and operation
module datapath
    import datapath_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear,
    input  logic [WIDTH-1:0] Mdatain,
    input  logic             Read,
    input  logic             PCout,
    input  logic             MDRout,
    input  logic             Zhighout,
    input  logic             Zlowout,
    input  logic             HIout,
    input  logic             LOout,
    input  logic [15:0]      R0_15_out,
    input  logic             MARin,
    input  logic             PCin,
    input  logic             MDRin,
    input  logic             IRin,
    input  logic             Yin,
    input  logic             HIin,
    input  logic             LOin,
    input  logic             Zhighin,
    input  logic             Zlowin,
    input  logic             R0in,
    input  logic             R6in,
    input  logic             R7in,
    input  logic             IncPC,
    input  logic             Cin,
    input  logic [4:0]       opcode
);

    logic [WIDTH-1:0]   pc_q, pc_d, ir_q, ir_d, y_q, y_d, mar_q, mar_d;
    logic [WIDTH-1:0]   mdr_q, mdr_d, hi_q, hi_d, lo_q, lo_d;
    logic [2*WIDTH-1:0] z_q, z_d;
    logic [WIDTH-1:0]   gpr_q [16];
    logic [WIDTH-1:0]   gpr_d [16];

    bus_src_e           bus_sel;
    logic [3:0]         gpr_idx;
    logic [WIDTH-1:0]   bus;
    logic [2*WIDTH-1:0] alu_c;

    // Resolve the winning source; later assignments override earlier ones,
    // so the lowest-priority sources are examined first.
    always_comb begin
        bus_sel = SRC_NONE;
        gpr_idx = '0;
        for (int i = 15; i >= 0; i--) begin
            if (R0_15_out[i]) begin
                bus_sel = SRC_GPR;
                gpr_idx = 4'(i);
            end
        end
        if (LOout)    bus_sel = SRC_LO;
        if (HIout)    bus_sel = SRC_HI;
        if (Zlowout)  bus_sel = SRC_ZLOW;
        if (Zhighout) bus_sel = SRC_ZHIGH;
        if (PCout)    bus_sel = SRC_PC;
        if (MDRout)   bus_sel = SRC_MDR;
    end

    always_comb begin
        case (bus_sel)
            SRC_MDR:   bus = mdr_q;
            SRC_PC:    bus = pc_q;
            SRC_ZHIGH: bus = z_q[2*WIDTH-1:WIDTH];
            SRC_ZLOW:  bus = z_q[WIDTH-1:0];
            SRC_HI:    bus = hi_q;
            SRC_LO:    bus = lo_q;
            SRC_GPR:   bus = gpr_q[gpr_idx];
            default:   bus = '0;
        endcase
    end

    datapath_alu #(.WIDTH(WIDTH)) u_alu (
        .a      (y_q),
        .b      (bus),
        .cin    (Cin),
        .opcode (opcode),
        .c      (alu_c)
    );

    always_comb begin
        pc_d  = pc_q;
        ir_d  = IRin  ? bus : ir_q;
        y_d   = Yin   ? bus : y_q;
        mar_d = MARin ? bus : mar_q;
        hi_d  = HIin  ? bus : hi_q;
        lo_d  = LOin  ? bus : lo_q;
        mdr_d = mdr_q;
        z_d   = z_q;
        gpr_d = gpr_q;

        if (MDRin) mdr_d = Read ? Mdatain : bus;
        if (PCin)  pc_d  = IncPC ? pc_q + WIDTH'(1) : bus;
        if (Zlowin)  z_d[WIDTH-1:0]         = alu_c[WIDTH-1:0];
        if (Zhighin) z_d[2*WIDTH-1:WIDTH]   = alu_c[2*WIDTH-1:WIDTH];
        // Only R0, R6 and R7 are loadable; the rest hold their reset value.
        if (R0in) gpr_d[0] = bus;
        if (R6in) gpr_d[6] = bus;
        if (R7in) gpr_d[7] = bus;
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            pc_q  <= '0;
            ir_q  <= '0;
            y_q   <= '0;
            mar_q <= '0;
            mdr_q <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            z_q   <= '0;
            for (int i = 0; i < 16; i++) gpr_q[i] <= '0;
        end else begin
            pc_q  <= pc_d;
            ir_q  <= ir_d;
            y_q   <= y_d;
            mar_q <= mar_d;
            mdr_q <= mdr_d;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            z_q   <= z_d;
            for (int i = 0; i < 16; i++) gpr_q[i] <= gpr_d[i];
        end
    end

endmodule

// File: tb/tb_datapath.sv
// tb/tb_datapath.sv - self-checking bench for datapath with a behavioural reference model
module tb_datapath;

    logic        clock = 1'b0;
    logic        clear;
    logic [31:0] Mdatain;
    logic        Read, PCout, MDRout, Zhighout, Zlowout, HIout, LOout;
    logic [15:0] R0_15_out;
    logic        MARin, PCin, MDRin, IRin, Yin, HIin, LOin, Zhighin, Zlowin;
    logic        R0in, R6in, R7in, IncPC, Cin;
    logic [4:0]  opcode;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] m_r [16];
    logic [31:0] m_pc, m_ir, m_y, m_mar, m_mdr, m_hi, m_lo;
    logic [63:0] m_z;

    datapath dut (
        .clock(clock), .clear(clear), .Mdatain(Mdatain), .Read(Read),
        .PCout(PCout), .MDRout(MDRout), .Zhighout(Zhighout), .Zlowout(Zlowout),
        .HIout(HIout), .LOout(LOout), .R0_15_out(R0_15_out),
        .MARin(MARin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin),
        .HIin(HIin), .LOin(LOin), .Zhighin(Zhighin), .Zlowin(Zlowin),
        .R0in(R0in), .R6in(R6in), .R7in(R7in), .IncPC(IncPC), .Cin(Cin),
        .opcode(opcode)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic idle_ctrl();
        Mdatain = '0; Read = 0; PCout = 0; MDRout = 0; Zhighout = 0; Zlowout = 0;
        HIout = 0; LOout = 0; R0_15_out = '0; MARin = 0; PCin = 0; MDRin = 0;
        IRin = 0; Yin = 0; HIin = 0; LOin = 0; Zhighin = 0; Zlowin = 0;
        R0in = 0; R6in = 0; R7in = 0; IncPC = 0; Cin = 0; opcode = '0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_r[i] = '0;
        m_pc = '0; m_ir = '0; m_y = '0; m_mar = '0; m_mdr = '0; m_hi = '0; m_lo = '0; m_z = '0;
    endtask

    function automatic logic [31:0] model_bus();
        if (MDRout)   return m_mdr;
        if (PCout)    return m_pc;
        if (Zhighout) return m_z[63:32];
        if (Zlowout)  return m_z[31:0];
        if (HIout)    return m_hi;
        if (LOout)    return m_lo;
        for (int i = 0; i < 16; i++)
            if (R0_15_out[i]) return m_r[i];
        return '0;
    endfunction

    function automatic logic [63:0] alu_ref(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic cin);
        int unsigned s = b[4:0];
        logic [31:0] r = a;
        longint t;
        case (op)
            5'd3:  begin t = longint'(a) + longint'(b) + longint'(cin); return {32'd0, t[31:0]}; end
            5'd4:  begin t = longint'(a) - longint'(b) - longint'(cin); return {32'd0, t[31:0]}; end
            5'd5:  return {32'd0, a & b};
            5'd6:  return {32'd0, a | b};
            5'd7:  begin t = longint'(a) / (longint'(1) << s); return {32'd0, t[31:0]}; end
            5'd8:  begin repeat (s) r = {r[31], r[31:1]}; return {32'd0, r}; end
            5'd9:  begin t = longint'(a) * (longint'(1) << s); return {32'd0, t[31:0]}; end
            5'd10: begin repeat (s) r = {r[0], r[31:1]}; return {32'd0, r}; end
            5'd11: begin repeat (s) r = {r[30:0], r[31]}; return {32'd0, r}; end
            5'd15: begin t = longint'(int'(a)) * longint'(int'(b)); return t; end
            5'd16: begin
                longint q, m;
                if (b == 0) return '0;
                q = longint'(int'(a)) / longint'(int'(b));
                m = longint'(int'(a)) % longint'(int'(b));
                return {m[31:0], q[31:0]};
            end
            5'd17: return {32'd0, 32'd0 - b};
            5'd18: return {32'd0, ~b};
            default: return '0;
        endcase
    endfunction

    task automatic check_regs(input string pfx);
        for (int i = 0; i < 16; i++) check($sformatf("%s_r%0d", pfx, i), dut.gpr_q[i], m_r[i]);
        check({pfx, "_pc"},  dut.pc_q,  m_pc);
        check({pfx, "_ir"},  dut.ir_q,  m_ir);
        check({pfx, "_y"},   dut.y_q,   m_y);
        check({pfx, "_mar"}, dut.mar_q, m_mar);
        check({pfx, "_mdr"}, dut.mdr_q, m_mdr);
        check({pfx, "_hi"},  dut.hi_q,  m_hi);
        check({pfx, "_lo"},  dut.lo_q,  m_lo);
        check({pfx, "_z"},   dut.z_q,   m_z);
    endtask

    // Apply the current controls for one clock: check the bus, advance the model,
    // then compare all registers just after the edge.
    task automatic cycle(input string pfx);
        logic [31:0] nb;
        logic [63:0] nc;
        #1;
        nb = model_bus();
        nc = alu_ref(opcode, m_y, nb, Cin);
        check({pfx, "_bus"}, dut.bus, nb);
        if (R0in) m_r[0] = nb;
        if (R6in) m_r[6] = nb;
        if (R7in) m_r[7] = nb;
        if (IRin)  m_ir  = nb;
        if (Yin)   m_y   = nb;
        if (MARin) m_mar = nb;
        if (HIin)  m_hi  = nb;
        if (LOin)  m_lo  = nb;
        if (MDRin) m_mdr = Read ? Mdatain : nb;
        if (PCin)  m_pc  = IncPC ? m_pc + 32'd1 : nb;
        if (Zlowin)  m_z[31:0]  = nc[31:0];
        if (Zhighin) m_z[63:32] = nc[63:32];
        @(posedge clock);
        #1;
        check_regs(pfx);
        idle_ctrl();
    endtask

    task automatic mem_to_reg(input logic [31:0] val, input int which);
        Mdatain = val; Read = 1; MDRin = 1;
        cycle("ld_mdr");
        MDRout = 1;
        case (which)
            0: R0in = 1;
            6: R6in = 1;
            7: R7in = 1;
            default: IRin = 1;
        endcase
        cycle("ld_reg");
    endtask

    task automatic rand_ctrl();
        idle_ctrl();
        Mdatain = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 >> $urandom_range(0, 31) : $urandom;
        Read = $urandom_range(0, 1) == 1;
        MDRout = $urandom_range(0, 7) == 0; PCout = $urandom_range(0, 7) == 0;
        Zhighout = $urandom_range(0, 7) == 0; Zlowout = $urandom_range(0, 7) == 0;
        HIout = $urandom_range(0, 7) == 0; LOout = $urandom_range(0, 7) == 0;
        case ($urandom_range(0, 3))
            1: R0_15_out = 16'd1 << $urandom_range(0, 15);
            2: R0_15_out = 16'($urandom);
            default: R0_15_out = '0;
        endcase
        MARin = $urandom_range(0, 2) == 0; PCin = $urandom_range(0, 2) == 0;
        MDRin = $urandom_range(0, 2) == 0; IRin = $urandom_range(0, 2) == 0;
        Yin = $urandom_range(0, 2) == 0; HIin = $urandom_range(0, 2) == 0;
        LOin = $urandom_range(0, 2) == 0; Zhighin = $urandom_range(0, 1) == 1;
        Zlowin = $urandom_range(0, 1) == 1; R0in = $urandom_range(0, 2) == 0;
        R6in = $urandom_range(0, 2) == 0; R7in = $urandom_range(0, 2) == 0;
        IncPC = $urandom_range(0, 1) == 1; Cin = $urandom_range(0, 1) == 1;
        opcode = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(3, 18));
    endtask

    initial begin
        idle_ctrl();
        model_reset();
        clear = 0;
        repeat (3) @(posedge clock);
        #1;
        check_regs("reset");
        check("reset_bus", dut.bus, 32'd0);
        clear = 1;

        mem_to_reg(32'h12, 7);
        check("r7_load", dut.gpr_q[7], 32'h0000_0012);
        mem_to_reg(32'h14, 6);
        check("r6_load", dut.gpr_q[6], 32'h0000_0014);

        PCin = 1; IncPC = 1;
        cycle("fetch_pc");
        check("pc_inc", dut.pc_q, 32'd1);
        mem_to_reg(32'h2891_8000, 99);
        check("ir_load", dut.ir_q, 32'h2891_8000);

        R0_15_out[7] = 1; opcode = 5'b10010; Zlowin = 1;
        cycle("not");
        check("not_zlow", dut.z_q[31:0], 32'hFFFF_FFED);
        Zlowout = 1; R6in = 1;
        cycle("not_mv");
        check("not_r6", dut.gpr_q[6], 32'hFFFF_FFED);

        mem_to_reg(32'd5, 7);
        mem_to_reg(32'd7, 6);
        R0_15_out[7] = 1; Yin = 1;
        cycle("y_r7");
        R0_15_out[6] = 1; opcode = 5'b00011; Cin = 1; Zlowin = 1;
        cycle("add");
        check("add_zlow", dut.z_q[31:0], 32'd13);
        R0_15_out[6] = 1; opcode = 5'b00100; Cin = 0; Zlowin = 1;
        cycle("sub");
        check("sub_zlow", dut.z_q[31:0], 32'hFFFF_FFFE);

        mem_to_reg(32'hFFFF_FFFE, 7);
        mem_to_reg(32'd3, 6);
        R0_15_out[7] = 1; Yin = 1;
        cycle("y_m2");
        R0_15_out[6] = 1; opcode = 5'b01111; Zhighin = 1; Zlowin = 1;
        cycle("mul");
        check("mul_z", dut.z_q, 64'hFFFF_FFFF_FFFF_FFFA);
        mem_to_reg(32'd7, 7);
        mem_to_reg(32'd2, 6);
        R0_15_out[7] = 1; Yin = 1;
        cycle("y_7");
        R0_15_out[6] = 1; opcode = 5'b10000; Zhighin = 1; Zlowin = 1;
        cycle("div");
        check("div_zlow", dut.z_q[31:0], 32'd3);
        check("div_zhigh", dut.z_q[63:32], 32'd1);
        Zhighout = 1; HIin = 1;
        cycle("hi");
        check("hi_load", dut.hi_q, 32'd1);

        // Self-transfer: R7 drives the bus and loads in the same cycle
        R0_15_out[7] = 1; R7in = 1;
        cycle("self");
        check("self_r7", dut.gpr_q[7], 32'd7);
        // IncPC alone must not move PC
        IncPC = 1;
        cycle("incpc_only");

        for (int n = 0; n < 400; n++) begin
            rand_ctrl();
            cycle("rand");
        end

        // Asynchronous reset in the middle of a cycle, with loads still requested
        rand_ctrl();
        #3;
        clear = 0;
        #1;
        model_reset();
        check_regs("async_rst");
        @(posedge clock);
        #1;
        check_regs("held_rst");
        clear = 1;
        idle_ctrl();
        PCin = 1; IncPC = 1;
        cycle("resume");
        check("resume_pc", dut.pc_q, 32'd1);
        for (int n = 0; n < 100; n++) begin
            rand_ctrl();
            cycle("rand2");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/datapath.md
Name: datapath

Overview:
- 32-bit single-bus datapath for the Mini-SRC processor.
- Contains:
  - general registers R0–R15
  - PC, IR, Y, MAR and MDR
  - a 64-bit Z result register (Zhigh/Zlow)
  - HI and LO registers
  - a combinational ALU
- All register transfers are driven by externally sequenced control signals from the control unit or a bench.

Parameters:
- WIDTH, 32, data/bus width; all registers are WIDTH bits, Z is 2*WIDTH.

Ports:
- clock  in  1  rising-edge clock
- clear  in  1  asynchronous active-low reset
- Mdatain  in  32  memory read data
- Read  in  1  MDR source select: 1 = Mdatain, 0 = bus
- PCout, MDRout, Zhighout, Zlowout, HIout, LOout  in  1 each  bus drive enables
- R0_15_out  in  16  bus drive enables, bit n = Rn
- MARin, PCin, MDRin, IRin, Yin, HIin, LOin, Zhighin, Zlowin  in  1 each  register load enables
- R0in, R6in, R7in  in  1 each  register load enables
- IncPC  in  1  PC increment qualifier
- Cin  in  1  carry-in for ADD/SUB
- opcode  in  5  ALU operation

Behaviour:
- Reset: clear=0 asynchronously zeroes every register (R0–R15, PC, IR, Y, MAR, MDR, HI, LO, Z).
- Bus (combinational):
  - Source priority, highest first: MDRout, PCout, Zhighout, Zlowout, HIout, LOout, then R0..R15 with the lowest index winning.
  - No source asserted → bus = 0.
- Register loads on the rising clock edge, each only when its enable is high:
  - Rn, IR, Y, MAR, HI, LO ← bus.
  - MDR ← (Read ? Mdatain : bus) when MDRin.
  - PC: PCin & IncPC → PC+1 (mod 2^32); PCin alone → bus. IncPC without PCin has no effect.
  - Z: Zlowin → Z[31:0] ← C[31:0]; Zhighin → Z[63:32] ← C[63:32]. The two halves load independently.
- Only R0, R6 and R7 have load ports. R1–R5 and R8–R15 stay 0 after reset but are still bus-readable.
- ALU is combinational. A = Y, B = bus, result C is 64-bit. Unless stated, C[63:32] = 0.
- Opcode map:
  - 00011 ADD: A+B+Cin.
  - 00100 SUB: A−B−Cin, two's complement.
  - 00101 AND, 00110 OR.
  - 00111 SHR: logical, by B[4:0].
  - 01000 SHRA: arithmetic, by B[4:0].
  - 01001 SHL: by B[4:0].
  - 01010 ROR, 01011 ROL: by B[4:0].
  - 01111 MUL: signed 32×32 → C[63:0].
  - 10000 DIV: signed; C[31:0] = quotient, C[63:32] = remainder. B=0 → C = 0.
  - 10001 NEG: −B.
  - 10010 NOT: ~B.
  - All other codes: C = 0.
- Y is not used by NEG or NOT.
- Bus and ALU settle within one cycle, so an out-enable and a load-enable may be asserted together for a single-cycle transfer. A register that both drives the bus and loads in the same cycle loads its own old value.
- Reset deasserted mid-operation: registers resume loading at the next rising edge.

Decomposition:
- Shared package holds the 5-bit opcode constants listed above, and the bus-source priority ordering.
- One natural sub-module: alu (inputs A, B, Cin, opcode; output C, 64 bits).
- Registers and the bus mux live in datapath.

Test Plan:
- Reset: hold clear=0, then release → all registers 0, and bus = 0 with no out-enables asserted.
- Load R7 and R6:
  - Mdatain=0x12, Read=1, MDRin=1 for 1 cycle, then MDRout=1, R7in=1 for 1 cycle → R7 = 0x00000012.
  - Same sequence with Mdatain=0x14 and R6in → R6 = 0x00000014.
- Fetch:
  - PCin=1, IncPC=1 for 1 cycle from reset → PC = 1.
  - Mdatain=0x28918000, Read=1, MDRin=1, then MDRout=1, IRin=1 → IR = 0x28918000.
- NOT:
  - With R7 = 0x12: R0_15_out[7]=1, opcode=10010, Zlowin=1 → Z[31:0] = 0xFFFFFFED.
  - Then Zlowout=1, R6in=1 → R6 = 0xFFFFFFED.
- ADD/SUB with carry:
  - Y=5 (from R7 via Yin), bus = R6 = 7, opcode=00011, Cin=1 → Zlow = 13.
  - SUB with Cin=0 → Zlow = 0xFFFFFFFE.
- MUL/DIV:
  - Y=0xFFFFFFFE (−2), bus=3, MUL, Zhighin=1 and Zlowin=1 → Z = 0xFFFFFFFF_FFFFFFFA.
  - DIV with Y=7, bus=2 → Zlow = 3, Zhigh = 1.
  - Zhighout with HIin → HI = 1.
